branch_predictor: RTL and testbench

- Fetch-stage branch predictor plus execute-stage resolution/redirect logic for the 5-stage RV32I hazard pipeline.
- The EX-stage branch comparator decides whether a branch is taken. This block is the other end of that decision: it predicts taken/target at IF, then consumes the EX resolution to train itself and flag mispredicts for the hazard unit.
- Direct-mapped BTB. Each entry holds valid, tag, target and a 2-bit saturating counter.

---
 rtl/branch_predictor_if.sv | 27 ++
 rtl/branch_predictor.sv | 96 +++++++++
 tb/tb_branch_predictor.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and execute-side branch resolution signals for branch_predictor.
// The master drives fetch PC and EX resolution; the slave (predictor) returns prediction and redirect.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational IF prediction,
// EX-stage training, mispredict/redirect generation and saturating resolution counters.
module branch_predictor #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned IDX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
);
  localparam int unsigned TAG_BITS = 32 - IDX_BITS - 2;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [31:0]         branch_cnt_q;
  logic [31:0]         mispredict_cnt_q;

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic                if_hit_c, ex_hit_c;
  logic                pred_taken_c, mispredict_c;
  logic [31:0]         pred_target_c, redirect_pc_c;
  logic [1:0]          ctr_inc_c, ctr_dec_c;
  logic                unused_pc_bits;

  assign if_idx = bp.if_pc[IDX_BITS+1:2];
  assign if_tag = bp.if_pc[31:IDX_BITS+2];
  assign ex_idx = bp.ex_pc[IDX_BITS+1:2];
  assign ex_tag = bp.ex_pc[31:IDX_BITS+2];
  assign unused_pc_bits = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

  // Prediction reads pre-update state, so a same-cycle write is seen only next cycle.
  always_comb begin
    if_hit_c      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken_c  = if_hit_c && ctr_q[if_idx][1];
    pred_target_c = pred_taken_c ? target_q[if_idx] : bp.if_pc + 32'd4;
  end

  always_comb begin
    ex_hit_c      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ctr_inc_c     = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
    ctr_dec_c     = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
    mispredict_c  = bp.ex_valid &&
                    ((bp.ex_taken != bp.ex_pred_taken) ||
                     (bp.ex_taken && (bp.ex_target != bp.ex_pred_target)));
    redirect_pc_c = bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4;
  end

  // BTB training; reset wins over a simultaneous resolution.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (bp.ex_valid) begin
      if (ex_hit_c) begin
        ctr_q[ex_idx] <= bp.ex_taken ? ctr_inc_c : ctr_dec_c;
        if (bp.ex_taken) begin
          target_q[ex_idx] <= bp.ex_target;
        end
      end else if (bp.ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= bp.ex_target;
        ctr_q[ex_idx]    <= 2'b10;
      end
    end
  end

  // Saturating resolution statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (bp.ex_valid && (branch_cnt_q != 32'hFFFF_FFFF)) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (mispredict_c && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  assign bp.pred_taken     = pred_taken_c;
  assign bp.pred_target    = pred_target_c;
  assign bp.mispredict     = mispredict_c;
  assign bp.redirect_pc    = redirect_pc_c;
  assign bp.branch_cnt     = branch_cnt_q;
  assign bp.mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios then random traffic,
// compared every cycle against a table-based reference predictor.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  branch_predictor_if bif ();

  branch_predictor #(.ENTRIES(16), .IDX_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bif.slave)
  );

  always #5 clk = ~clk;

  // Reference predictor: one slot per index, keyed by pc/64, counter kept as an integer 0..3.
  bit          m_valid [16];
  bit [31:0]   m_owner [16];
  bit [31:0]   m_tgt   [16];
  int          m_ctr   [16];
  bit [31:0]   m_brc, m_mpc;

  function automatic int slot(input bit [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit model_hit(input bit [31:0] pc);
    return m_valid[slot(pc)] && (m_owner[slot(pc)] == pc / 64);
  endfunction

  function automatic bit model_ptaken(input bit [31:0] pc);
    return model_hit(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  function automatic bit [31:0] model_ptarget(input bit [31:0] pc);
    return model_ptaken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  function automatic bit model_mispredict();
    if (!bif.ex_valid) return 1'b0;
    if (bif.ex_taken != bif.ex_pred_taken) return 1'b1;
    return bif.ex_taken && (bif.ex_target != bif.ex_pred_target);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_owner[i] = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_brc = '0;
    m_mpc = '0;
  endtask

  // Applies one clock edge of training to the model, using pre-edge state.
  task automatic model_edge();
    bit mp;
    int s;
    if (rst) begin
      model_reset();
      return;
    end
    if (!bif.ex_valid) return;
    mp = model_mispredict();
    s  = slot(bif.ex_pc);
    if (m_brc != 32'hFFFF_FFFF) m_brc++;
    if (mp && m_mpc != 32'hFFFF_FFFF) m_mpc++;
    if (model_hit(bif.ex_pc)) begin
      if (bif.ex_taken) begin
        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
        m_tgt[s] = bif.ex_target;
      end else begin
        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
      end
    end else if (bif.ex_taken) begin
      m_valid[s] = 1'b1;
      m_owner[s] = bif.ex_pc / 64;
      m_tgt[s]   = bif.ex_target;
      m_ctr[s]   = 2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: check combinational outputs, clock, update model, check registered counts.
  task automatic tick();
    bit mp;
    #1;
    mp = model_mispredict();
    check("pred_taken",  32'(bif.pred_taken),  32'(model_ptaken(bif.if_pc)));
    check("pred_target", bif.pred_target,      model_ptarget(bif.if_pc));
    check("mispredict",  32'(bif.mispredict),  32'(mp));
    if (mp) check("redirect_pc", bif.redirect_pc,
                  bif.ex_taken ? bif.ex_target : bif.ex_pc + 32'd4);
    @(posedge clk);
    model_edge();
    #1;
    check("branch_cnt",     bif.branch_cnt,     m_brc);
    check("mispredict_cnt", bif.mispredict_cnt, m_mpc);
  endtask

  task automatic drive_ex(input bit v, input bit [31:0] pc, input bit t, input bit [31:0] tgt,
                          input bit pt, input bit [31:0] ptgt);
    bif.ex_valid       = v;
    bif.ex_pc          = pc;
    bif.ex_taken       = t;
    bif.ex_target      = tgt;
    bif.ex_pred_taken  = pt;
    bif.ex_pred_target = ptgt;
  endtask

  task automatic idle();
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    bit [31:0] pool [6];
    bit [31:0] pc;
    pool[0] = 32'h100; pool[1] = 32'h140; pool[2] = 32'h104;
    pool[3] = 32'h200; pool[4] = 32'hFFFF_FFFC; pool[5] = 32'h1100;
    model_reset();
    rst = 1'b1;
    bif.if_pc = 32'h100;
    idle();
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // Reset state
    #1;
    check("rst_pred_taken",  32'(bif.pred_taken), 32'h0);
    check("rst_pred_target", bif.pred_target,     32'h104);
    check("rst_branch_cnt",  bif.branch_cnt,      32'h0);
    tick();

    // First taken resolution allocates and mispredicts
    drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    check("alloc_mispredict", 32'(bif.mispredict), 32'h1);
    check("alloc_redirect",   bif.redirect_pc,     32'h80);
    tick();
    idle();
    #1;
    check("alloc_pred_taken",  32'(bif.pred_taken), 32'h1);
    check("alloc_pred_target", bif.pred_target,     32'h80);
    check("alloc_counts",      {bif.branch_cnt[15:0], bif.mispredict_cnt[15:0]}, 32'h0001_0001);
    tick();

    // Train to strong-T, then two not-taken resolutions
    drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    tick();
    tick();
    drive_ex(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    check("nt_redirect", bif.redirect_pc, 32'h104);
    tick();
    idle();
    #1;
    check("weak_t_pred", 32'(bif.pred_taken), 32'h1);
    tick();
    drive_ex(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    tick();
    idle();
    #1;
    check("weak_nt_pred", 32'(bif.pred_taken), 32'h0);
    tick();

    // Aliasing entry at same index replaces the old one
    bif.if_pc = 32'h140;
    tick();
    drive_ex(1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    tick();
    idle();
    #1;
    check("alias_target", bif.pred_target, 32'h200);
    tick();
    bif.if_pc = 32'h100;
    #1;
    check("alias_evicted", 32'(bif.pred_taken), 32'h0);
    tick();

    // Same-cycle read during allocating write
    drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    check("rdw_old", 32'(bif.pred_taken), 32'h0);
    tick();
    idle();
    #1;
    check("rdw_new", 32'(bif.pred_taken), 32'h1);
    tick();

    // Direction right, target wrong
    drive_ex(1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    #1;
    check("tgt_mismatch_redirect", bif.redirect_pc, 32'h90);
    tick();

    // Reset with a simultaneous update
    rst = 1'b1;
    drive_ex(1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h90);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("post_rst_pred",    32'(bif.pred_taken), 32'h0);
    check("post_rst_mpcount", bif.mispredict_cnt,  32'h0);
    tick();

    // Address wrap at top of memory
    bif.if_pc = 32'hFFFF_FFFC;
    drive_ex(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10);
    #1;
    check("wrap_pred_target", bif.pred_target, 32'h0);
    check("wrap_redirect",    bif.redirect_pc, 32'h0);
    tick();

    // Random traffic over a small PC pool to exercise hits, aliases and training
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 60) == 0);
      bif.if_pc = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                              : pool[$urandom_range(0, 5)];
      pc = pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 1)
        drive_ex(1'b1, pc, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)],
                 model_ptaken(pc), model_ptarget(pc));
      else
        drive_ex(1'($urandom_range(0, 2) != 0), pc, 1'($urandom_range(0, 1)),
                 $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom());
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
